// File: rtl/mem_arbiter.sv
// mem_arbiter: one fixed-latency single-port SRAM shared by IF fetch and MEM load/store.
// Latency: ready pulses WAIT_CYCLES+1 cycles after the granting cycle; each requester holds
// its request until its ready pulse. Build option MEM_ARB_ROUND_ROBIN_EN alternates tie priority.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_rd_req,
  input  logic              mem_wr_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       owner_mem;
  logic       if_cancel;
  logic       if_ready_q;
  logic       mem_any;
  logic       if_live;
  logic       grant_mem;
  logic       grant_if;
  logic       if_kill;

  assign mem_any = mem_rd_req | mem_wr_req;
  assign if_live = if_req & ~if_flush;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_if;
  assign grant_mem = mem_any & (~if_live | last_if);
`else
  assign grant_mem = mem_any;
`endif

  assign grant_if = if_live & ~grant_mem;
  // A flush on the final access cycle cancels just like an earlier one.
  assign if_kill  = if_cancel | if_flush;
  // A flush arriving in RESP still has to swallow the pulse, hence the late gate.
  assign if_ready = if_ready_q & ~if_flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      owner_mem  <= 1'b0;
      if_cancel  <= 1'b0;
      if_ready_q <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      mem_ready  <= 1'b0;
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      busy       <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_if    <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_mem | grant_if) begin
            state      <= ACCESS;
            cnt        <= CNT_INIT;
            owner_mem  <= grant_mem;
            if_cancel  <= 1'b0;
            sram_en    <= 1'b1;
            sram_we    <= grant_mem & mem_wr_req;
            sram_addr  <= grant_mem ? mem_addr : if_addr;
            sram_wdata <= grant_mem ? mem_wdata : '0;
            busy       <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_if    <= grant_if;
`endif
          end
        end
        ACCESS: begin
          if (!owner_mem && if_flush) begin
            if_cancel <= 1'b1;
          end
          if (cnt == 4'd0) begin
            state   <= RESP;
            sram_en <= 1'b0;
            sram_we <= 1'b0;
            if (owner_mem) begin
              mem_ready <= 1'b1;
              if (!sram_we) begin
                mem_rdata <= sram_rdata;
              end
            end else if (!if_kill) begin
              if_ready_q <= 1'b1;
              if_rdata   <= sram_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state      <= IDLE;
          busy       <= 1'b0;
          mem_ready  <= 1'b0;
          if_ready_q <= 1'b0;
          if_cancel  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: transaction-level model, behavioural SRAM, randomized scenarios.
module tb_mem_arbiter;

  localparam int W = 3;

  typedef struct {
    bit          is_mem;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic        if_flush = 1'b0;
  logic        mem_rd_req = 1'b0;
  logic        mem_wr_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata, sram_rdata;
  logic        if_ready, mem_ready, sram_en, sram_we, busy;

  logic        if1_req = 1'b0;
  logic [31:0] if1_addr = '0;
  logic [31:0] if1_rdata, mem1_rdata, sram1_addr, sram1_wdata, sram1_rdata;
  logic        if1_ready, mem1_ready, sram1_en, sram1_we, busy1;

  int          cyc = 0;
  int          vectors = 0;
  int          errors = 0;
  exp_t        expq[$];
  exp_t        mon_e;

  logic [31:0] ref_mem [1024];
  logic [31:0] m_if_rd;
  logic [31:0] m_mem_rd;
  bit          m_last_if;

  logic [31:0] sram [1024];
  bit          wflag [1024];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int idx);
    if (idx == 0) return 32'hE3A00014;
    return (32'(idx) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  always @(posedge clk) begin
    if (sram_en && sram_we) begin
      sram[sram_addr[11:2]]  <= sram_wdata;
      wflag[sram_addr[11:2]] <= 1'b1;
    end
  end
  assign sram_rdata  = wflag[sram_addr[11:2]] ? sram[sram_addr[11:2]]
                                              : init_word(int'(sram_addr[11:2]));
  assign sram1_rdata = init_word(int'(sram1_addr[11:2]));

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if1_req), .if_addr(if1_addr), .if_flush(1'b0),
    .if_rdata(if1_rdata), .if_ready(if1_ready),
    .mem_rd_req(1'b0), .mem_wr_req(1'b0), .mem_addr(32'd0),
    .mem_wdata(32'd0), .mem_rdata(mem1_rdata), .mem_ready(mem1_ready),
    .sram_en(sram1_en), .sram_we(sram1_we), .sram_addr(sram1_addr),
    .sram_wdata(sram1_wdata), .sram_rdata(sram1_rdata), .busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the head of the expected-response queue.
  always @(negedge clk) begin
    if (rst && (if_ready || mem_ready)) begin
      if (expq.size() == 0) begin
        check("unexpected_ready", {30'd0, if_ready, mem_ready}, 32'd0);
      end else begin
        mon_e = expq.pop_front();
        check("ready_port", {30'd0, if_ready, mem_ready}, mon_e.is_mem ? 32'd1 : 32'd2);
        check("ready_cycle", cyc, mon_e.cyc);
        check(mon_e.is_mem ? "mem_rdata" : "if_rdata",
              mon_e.is_mem ? mem_rdata : if_rdata, mon_e.data);
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_if_rdata"}, if_rdata, 32'd0);
    check({tag, "_if_ready"}, {31'd0, if_ready}, 32'd0);
    check({tag, "_mem_rdata"}, mem_rdata, 32'd0);
    check({tag, "_mem_ready"}, {31'd0, mem_ready}, 32'd0);
    check({tag, "_sram_en"}, {31'd0, sram_en}, 32'd0);
    check({tag, "_sram_we"}, {31'd0, sram_we}, 32'd0);
    check({tag, "_sram_addr"}, sram_addr, 32'd0);
    check({tag, "_sram_wdata"}, sram_wdata, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // One scenario: requests raised together; flush_k = cycle of a one-cycle flush (-1: none).
  task automatic run(input bit do_if, input bit do_mem, input bit wr,
                     input logic [31:0] ia, input logic [31:0] ma, input logic [31:0] wd,
                     input int flush_k);
    bit          s_we [2];
    logic [31:0] s_addr [2];
    exp_t        e;
    int          n, d, t0, rc, i, j, p;
    bit          mem_first, seen_if, seen_mem, exp_en, exp_busy;
    n = 0;
    seen_if = 0;
    seen_mem = 0;
    d = (do_if && !do_mem && flush_k == 0) ? 1 : 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    mem_first = do_mem && (!do_if || m_last_if);
`else
    mem_first = do_mem;
`endif
    @(posedge clk); #1;
    t0 = cyc;
    for (int slot = 0; slot < 3; slot++) begin
      rc = t0 + d + W + 1 + n * (W + 2);
      if ((slot == 0 && mem_first) || (slot == 2 && do_mem && !mem_first)) begin
        s_addr[n] = ma;
        s_we[n] = wr;
        if (wr) ref_mem[ma[11:2]] = wd;
        else m_mem_rd = ref_mem[ma[11:2]];
        e.is_mem = 1'b1; e.data = m_mem_rd; e.cyc = rc;
        expq.push_back(e);
        m_last_if = 1'b0;
        n++;
      end else if (slot == 1 && do_if) begin
        s_addr[n] = ia;
        s_we[n] = 1'b0;
        if (flush_k < 1) begin
          m_if_rd = ref_mem[ia[11:2]];
          e.is_mem = 1'b0; e.data = m_if_rd; e.cyc = rc;
          expq.push_back(e);
        end
        m_last_if = 1'b1;
        n++;
      end
    end
    if_req = do_if;
    if_addr = ia;
    mem_wr_req = do_mem && wr;
    mem_rd_req = do_mem && (!wr || ($urandom_range(0, 1) == 1));
    mem_addr = ma;
    mem_wdata = wd;
    for (int k = 0; k <= n * (W + 2) + d; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (seen_if) if_req = 1'b0;
      if (seen_mem) begin mem_rd_req = 1'b0; mem_wr_req = 1'b0; end
      if_flush = (k == flush_k);
      if (k == flush_k && k > 0) if_req = 1'b0;
      @(negedge clk);
      j = k - d;
      i = 0;
      exp_en = 0;
      exp_busy = 0;
      if (j >= 1) begin
        i = (j - 1) / (W + 2);
        p = j - i * (W + 2);
        if (i < n) begin
          exp_en = (p <= W);
          exp_busy = (p <= W + 1);
        end
      end
      check("sram_en", {31'd0, sram_en}, {31'd0, exp_en});
      check("busy", {31'd0, busy}, {31'd0, exp_busy});
      if (exp_en) begin
        check("sram_addr", sram_addr, s_addr[i]);
        check("sram_we", {31'd0, sram_we}, {31'd0, s_we[i]});
        if (s_we[i]) check("sram_wdata", sram_wdata, wd);
      end
      seen_if = if_ready;
      seen_mem = mem_ready;
    end
    if_req = 1'b0;
    if_flush = 1'b0;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    check("missing_ready", expq.size(), 32'd0);
    expq.delete();
  endtask

  task automatic reset_mid_store();
    @(posedge clk); #1;
    mem_wr_req = 1'b1; mem_addr = 32'd2048; mem_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_wr_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    m_if_rd = '0;
    m_mem_rd = '0;
    m_last_if = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    repeat (W + 3) @(negedge clk);
    check("midrst_idle_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait1_fetch();
    for (int k = 0; k <= 3; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin if1_req = 1'b1; if1_addr = 32'd148; end
      if (k == 3) if1_req = 1'b0;
      @(negedge clk);
      check("w1_sram_en", {31'd0, sram1_en}, (k == 1) ? 32'd1 : 32'd0);
      check("w1_busy", {31'd0, busy1}, (k == 1 || k == 2) ? 32'd1 : 32'd0);
      check("w1_if_ready", {31'd0, if1_ready}, (k == 2) ? 32'd1 : 32'd0);
      if (k == 1) check("w1_sram_addr", sram1_addr, 32'd148);
      if (k == 1) check("w1_sram_we", {31'd0, sram1_we}, 32'd0);
      if (k == 2) check("w1_if_rdata", if1_rdata, init_word(37));
    end
    check("w1_mem_side", {mem1_rdata[30:0], mem1_ready}, 32'd0);
  endtask

  initial begin
    int typ, fk;
    logic [31:0] ra, rb, rd;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    m_if_rd = '0;
    m_mem_rd = '0;
    m_last_if = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    run(1, 0, 0, 32'd0, 32'd0, 32'd0, -1);
    run(0, 1, 1, 32'd0, 32'd1024, 32'h00000014, -1);
    run(0, 1, 0, 32'd0, 32'd1024, 32'd0, -1);
    run(1, 1, 0, 32'd4, 32'd1028, 32'd0, -1);
    run(1, 1, 0, 32'd4, 32'd1028, 32'd0, -1);
    run(1, 0, 0, 32'd8, 32'd0, 32'd0, 2);
    check("flush_if_rdata_hold", if_rdata, m_if_rd);
    run(1, 0, 0, 32'd12, 32'd0, 32'd0, 0);
    run(1, 0, 0, 32'd16, 32'd0, 32'd0, W + 1);
    run(1, 0, 0, 32'd16, 32'd0, 32'd0, -1);
    reset_mid_store();
    wait1_fetch();

    for (int s = 0; s < 200; s++) begin
      typ = int'($urandom_range(0, 3));
      ra = 32'($urandom_range(0, 255)) << 2;
      rb = (typ == 3) ? ra : (32'($urandom_range(0, 255)) << 2);
      rd = $urandom;
      fk = -1;
      if (typ == 0 && $urandom_range(0, 2) == 0) fk = int'($urandom_range(0, W));
      run(typ != 1, typ != 0, $urandom_range(0, 1) == 1, ra, rb, rd, fk);
      if (fk >= 0) check("rand_flush_if_rdata", if_rdata, m_if_rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
